// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run-sequencing controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Defaults shared with the core top level.
    localparam int unsigned DEF_HALT_PC = 128;
    localparam int unsigned DEF_MAX_CYC = 16'hFFFF;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and an at-limit flag.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt,
    output logic         o_at_limit
);

    logic [W-1:0] r_cnt;

    // Count while enabled, stop at the limit; clear has priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != i_limit))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt      = r_cnt;
    assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/run_ctrl.sv
// Run-sequencing controller: core reset/run/halt sequence, cycle count with
// timeout, and data-memory ownership arbitration with the external port.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int             D       = 12,
    parameter logic [D-1:0]   HALT_PC = D'(DEF_HALT_PC),
    parameter int             CW      = 16,
    parameter logic [CW-1:0]  MAX_CYC = CW'(DEF_MAX_CYC),
    parameter int             CLR_CYC = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req,
    input  logic [D-1:0]  i_prog_ctr,
    input  logic          i_ext_req,
    output logic          o_core_rst,
    output logic          o_core_en,
    output logic          o_mem_sel,
    output logic          o_ext_gnt,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_timeout,
    output logic [CW-1:0] o_cycle_cnt
);

    localparam int HW = $clog2(CLR_CYC + 1);

    state_t          r_state, w_next;
    logic            r_core_rst, r_core_en, r_gnt, r_busy, r_done, r_timeout;
    logic            w_gnt_nxt, w_to_nxt;
    logic            w_cyc_at_lim, w_hold_at_lim;
    logic [HW-1:0]   w_hold_cnt;

    // Cycles spent in RUN; zeroed on the way into CLEAR.
    sat_counter #(.W(CW)) u_cyc_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_reset),
        .i_clr      ((r_state == S_IDLE) && (w_next == S_CLEAR)),
        .i_en       (r_state == S_RUN),
        .i_limit    (MAX_CYC),
        .o_cnt      (o_cycle_cnt),
        .o_at_limit (w_cyc_at_lim)
    );

    // Core-reset hold time; idles at zero outside CLEAR.
    sat_counter #(.W(HW)) u_hold_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_reset),
        .i_clr      (r_state != S_CLEAR),
        .i_en       (1'b1),
        .i_limit    (HW'(CLR_CYC - 1)),
        .o_cnt      (w_hold_cnt),
        .o_at_limit (w_hold_at_lim)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state, grant and timeout decisions.
    always_comb begin
        w_next    = r_state;
        w_gnt_nxt = r_gnt;
        w_to_nxt  = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (r_gnt) begin
                    if (!i_ext_req) w_gnt_nxt = 1'b0;
                end else if (i_req) begin
                    w_next   = S_CLEAR;
                    w_to_nxt = 1'b0;
                end else if (i_ext_req) begin
                    w_gnt_nxt = 1'b1;
                end
            end
            S_CLEAR: if (w_hold_at_lim) w_next = S_RUN;
            S_RUN: begin
                // Halt beats timeout when both land in the same cycle.
                if (i_prog_ctr == HALT_PC) begin
                    w_next = S_DRAIN;
                end else if (w_cyc_at_lim) begin
                    w_next   = S_DRAIN;
                    w_to_nxt = 1'b1;
                end
            end
            S_DRAIN: w_next = S_DONE;
            S_DONE: begin
                // Readback grant first; leave only once the port is released.
                if (r_gnt) begin
                    if (!i_ext_req) w_gnt_nxt = 1'b0;
                end else if (i_ext_req) begin
                    w_gnt_nxt = 1'b1;
                end else if (!i_req) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_core_rst <= 1'b1;
            r_core_en  <= 1'b0;
            r_gnt      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_core_rst <= (w_next == S_IDLE) || (w_next == S_CLEAR);
            r_core_en  <= (w_next == S_RUN);
            r_gnt      <= w_gnt_nxt;
            r_busy     <= (w_next == S_CLEAR) || (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done     <= (w_next == S_DONE);
            r_timeout  <= w_to_nxt;
        end
    end

    assign o_core_rst = r_core_rst;
    assign o_core_en  = r_core_en;
    assign o_mem_sel  = r_gnt;
    assign o_ext_gnt  = r_gnt;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus randomized req/ext_req/prog_ctr
// traffic, every cycle compared against a phase-level reference model.
module tb_run_ctrl;

    localparam int D       = 12;
    localparam int CW      = 16;
    localparam int MAXC    = 20;
    localparam int HALT    = 128;
    localparam int CLRC    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req = 1'b0;
    logic          ext_req = 1'b0;
    logic [D-1:0]  pc = 12'd0;
    logic          core_rst, core_en, mem_sel, ext_gnt, busy, done, timeout;
    logic [CW-1:0] cycle_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    run_ctrl #(
        .D(D), .HALT_PC(12'(HALT)), .CW(CW), .MAX_CYC(16'(MAXC)), .CLR_CYC(CLRC)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_prog_ctr(pc),
        .i_ext_req(ext_req), .o_core_rst(core_rst), .o_core_en(core_en),
        .o_mem_sel(mem_sel), .o_ext_gnt(ext_gnt), .o_busy(busy),
        .o_done(done), .o_timeout(timeout), .o_cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 clear, 2 run, 3 drain, 4 done.
    int m_ph = 0, m_clr_left = 0, m_cnt = 0;
    bit m_to = 0, m_gnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_clr_left = 0; m_cnt = 0; m_to = 0; m_gnt = 0;
        end else begin
            case (m_ph)
                0: if (m_gnt) begin
                       if (!ext_req) m_gnt = 0;
                   end else if (req) begin
                       m_ph = 1; m_clr_left = CLRC; m_cnt = 0; m_to = 0;
                   end else if (ext_req) m_gnt = 1;
                1: begin
                       m_clr_left--;
                       if (m_clr_left == 0) m_ph = 2;
                   end
                2: begin
                       int prev;
                       prev = m_cnt;
                       if (m_cnt < MAXC) m_cnt++;
                       if (pc == HALT) m_ph = 3;
                       else if (prev == MAXC) begin m_ph = 3; m_to = 1; end
                   end
                3: m_ph = 4;
                default: if (m_gnt) begin
                       if (!ext_req) m_gnt = 0;
                   end else if (ext_req) m_gnt = 1;
                   else if (!req) m_ph = 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("core_rst", 32'(core_rst), 32'(m_ph <= 1));
            chk("core_en",  32'(core_en),  32'(m_ph == 2));
            chk("busy",     32'(busy),     32'(m_ph >= 1 && m_ph <= 3));
            chk("done",     32'(done),     32'(m_ph == 4));
            chk("ext_gnt",  32'(ext_gnt),  32'(m_gnt));
            chk("mem_sel",  32'(mem_sel),  32'(m_gnt));
            chk("timeout",  32'(timeout),  32'(m_to));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
            if (ext_gnt && busy) begin
                n_err++;
                $display("FAIL gnt_while_busy: got 1 expected 0 at %0t", $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [D-1:0] rnd_pc();
        logic [D-1:0] v;
        v = D'($urandom_range(0, 4095));
        if (v == D'(HALT)) v = v + 1'b1;
        return v;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, ".core_en"},  32'(core_en),  32'd0);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".gnt"},      32'(ext_gnt),  32'd0);
        chk({tag, ".mem_sel"},  32'(mem_sel),  32'd0);
        chk({tag, ".timeout"},  32'(timeout),  32'd0);
        chk({tag, ".cnt"},      32'(cycle_cnt), 32'd0);
    endtask

    // Leave DONE and settle in IDLE.
    task automatic finish_run();
        req = 0; ext_req = 0; pc = rnd_pc();
        tick(3);
        chk("back_idle", 32'(busy | done), 32'd0);
    endtask

    initial begin
        pc = rnd_pc();
        #1 rst_n = 0;
        #1;
        chk_reset_vals("reset");
        chk_on = 1;
        tick(2);

        // Halt run: req at cycle 0, prog_ctr=128 at cycle 10.
        rst_n = 1; req = 1;
        tick(2);
        chk("t1.rst_c2", 32'(core_rst), 32'd1);
        chk("t1.en_c2",  32'(core_en),  32'd0);
        tick(1);
        chk("t1.en_c3",  32'(core_en),  32'd1);
        chk("t1.rst_c3", 32'(core_rst), 32'd0);
        tick(7);
        pc = 12'(HALT);
        tick(1);
        chk("t1.drain_en",   32'(core_en), 32'd0);
        chk("t1.drain_busy", 32'(busy),    32'd1);
        pc = rnd_pc();
        tick(1);
        chk("t1.done", 32'(done),      32'd1);
        chk("t1.cnt",  32'(cycle_cnt), 32'd8);
        chk("t1.to",   32'(timeout),   32'd0);
        finish_run();

        // Timeout run: prog_ctr never reaches HALT.
        req = 1;
        tick(23);
        chk("t2.cnt_lim", 32'(cycle_cnt), 32'(MAXC));
        chk("t2.en_lim",  32'(core_en),   32'd1);
        tick(2);
        chk("t2.done", 32'(done),      32'd1);
        chk("t2.to",   32'(timeout),   32'd1);
        chk("t2.cnt",  32'(cycle_cnt), 32'(MAXC));
        finish_run();

        // Arbitration: grant holds off a start request.
        ext_req = 1;
        tick(1);
        chk("t3.gnt", 32'(ext_gnt), 32'd1);
        chk("t3.sel", 32'(mem_sel), 32'd1);
        req = 1;
        tick(3);
        chk("t3.held", 32'(busy), 32'd0);
        ext_req = 0;
        tick(1);
        chk("t3.gnt_drop", 32'(ext_gnt), 32'd0);
        chk("t3.still_idle", 32'(busy), 32'd0);
        tick(1);
        chk("t3.clear", 32'(busy & core_rst), 32'd1);
        tick(4);
        pc = 12'(HALT);
        tick(2);
        pc = rnd_pc();
        tick(1);
        chk("t3.done", 32'(done), 32'd1);
        finish_run();

        // Same-cycle req and ext_req: run first, grant only in DONE.
        req = 1; ext_req = 1;
        tick(1);
        chk("t4.clear", 32'(busy), 32'd1);
        chk("t4.nogrant", 32'(ext_gnt), 32'd0);
        tick(9);
        pc = 12'(HALT);
        tick(2);
        pc = rnd_pc();
        chk("t4.done", 32'(done), 32'd1);
        chk("t4.nogrant_done", 32'(ext_gnt), 32'd0);
        tick(1);
        chk("t4.grant", 32'(ext_gnt), 32'd1);
        req = 0;
        tick(2);
        chk("t4.stay_done", 32'(done), 32'd1);
        ext_req = 0;
        tick(1);
        chk("t4.gnt_drop", 32'(ext_gnt), 32'd0);
        chk("t4.done_hold", 32'(done), 32'd1);
        tick(1);
        chk("t4.idle", 32'(done), 32'd0);
        finish_run();

        // Async reset mid-run with cycle_cnt=5, then restart from zero.
        req = 1;
        tick(8);
        chk("t5.cnt5", 32'(cycle_cnt), 32'd5);
        #2 rst_n = 0; req = 0;
        #1;
        chk_reset_vals("t5.async");
        tick(2);
        rst_n = 1; req = 1;
        tick(3);
        chk("t5.cnt0", 32'(cycle_cnt), 32'd0);
        tick(1);
        chk("t5.cnt1", 32'(cycle_cnt), 32'd1);
        chk("t5.nodone", 32'(done), 32'd0);
        tick(19);
        chk("t6.cnt_lim", 32'(cycle_cnt), 32'(MAXC));
        pc = 12'(HALT);
        tick(1);
        pc = rnd_pc();
        tick(1);
        chk("t6.done", 32'(done), 32'd1);
        chk("t6.to", 32'(timeout), 32'd0);
        finish_run();

        // Randomized traffic, model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            if ($urandom_range(0, 9) == 0) ext_req = ~ext_req;
            pc = ($urandom_range(0, 19) == 0) ? 12'(HALT) : rnd_pc();
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
